// File: rtl/pulse_window_checker.sv
// pulse_window_checker: watches CStart/CEnd pulse pairs and checks that each
// CEnd arrives as a single-cycle pulse within [MIN_CYC, MAX_CYC] cycles of
// its CStart. Violations latch a sticky error with the first error code,
// bump a saturating counter and park the FSM in ERROR until ErrorRst.
module pulse_window_checker #(
    parameter int CNT_W            = 4,
    parameter int MIN_CYC          = 2,
    parameter int MAX_CYC          = 2,
    parameter int ERRCNT_W         = 8,
    parameter bit RESTART_ON_START = 1'b0,
    parameter bit STRAY_CHECK      = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                CStart,
    input  logic                CEnd,
    input  logic                ErrorRst,
    output logic                Busy,
    output logic                Error,
    output logic [2:0]          ErrCode,
    output logic [ERRCNT_W-1:0] ErrCnt,
    output logic [CNT_W-1:0]    LastLat
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_END, S_ERROR} state_t;

    localparam logic [2:0] E_EARLY   = 3'd1;
    localparam logic [2:0] E_LATE    = 3'd2;
    localparam logic [2:0] E_WIDTH   = 3'd3;
    localparam logic [2:0] E_OVERLAP = 3'd4;
    localparam logic [2:0] E_STRAY   = 3'd5;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic [2:0]            errcode_q, errcode_d;
    logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
    logic [CNT_W-1:0]      lastlat_q, lastlat_d;

    // Entry into ERROR on this edge, with the code that caused it
    logic                  raise;
    logic [2:0]            raise_code;
    // Legal CEnd seen: capture the measured latency
    logic                  lat_ld;

    // State register; Rst aborts any transaction without logging an error
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and latency counter; CEnd is judged before CStart in COUNT
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raise      = 1'b0;
        raise_code = 3'd0;
        lat_ld     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CStart) begin
                    state_d = S_COUNT;
                    cnt_d   = ONE_C;
                end else if (CEnd && STRAY_CHECK) begin
                    raise      = 1'b1;
                    raise_code = E_STRAY;
                end
            end
            S_COUNT: begin
                if (CEnd) begin
                    if (cnt_q < MIN_C) begin
                        raise      = 1'b1;
                        raise_code = E_EARLY;
                    end else begin
                        state_d = S_END;
                        lat_ld  = 1'b1;
                    end
                end else if (CStart) begin
                    if (RESTART_ON_START) begin
                        cnt_d = ONE_C;
                    end else begin
                        raise      = 1'b1;
                        raise_code = E_OVERLAP;
                    end
                end else if (cnt_q == MAX_C) begin
                    raise      = 1'b1;
                    raise_code = E_LATE;
                end else begin
                    // Cannot wrap: MAX_C <= all-ones and the check above fires first
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_END: begin
                if (CEnd) begin
                    raise      = 1'b1;
                    raise_code = E_WIDTH;
                end else if (CStart) begin
                    state_d = S_COUNT;
                    cnt_d   = ONE_C;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (ErrorRst) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (raise) state_d = S_ERROR;
    end

    // Next values of the registered outputs, so they change on the same edge as the state
    always_comb begin
        busy_d    = (state_d == S_COUNT) || (state_d == S_END);
        error_d   = error_q;
        errcode_d = errcode_q;
        errcnt_d  = errcnt_q;
        lastlat_d = lat_ld ? cnt_q : lastlat_q;
        if (raise) begin
            error_d   = 1'b1;
            errcode_d = raise_code;
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
        end else if (state_q == S_ERROR && ErrorRst) begin
            error_d   = 1'b0;
            errcode_d = 3'd0;
        end
    end

    // Counter and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            errcode_q <= 3'd0;
            errcnt_q  <= '0;
            lastlat_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            errcode_q <= errcode_d;
            errcnt_q  <= errcnt_d;
            lastlat_q <= lastlat_d;
        end
    end

    assign Busy    = busy_q;
    assign Error   = error_q;
    assign ErrCode = errcode_q;
    assign ErrCnt  = errcnt_q;
    assign LastLat = lastlat_q;

endmodule

// File: doc/pulse_window_checker.md
Name: pulse_window_checker

Overview:
- Parametrised start/end timing monitor. Checks that each CStart pulse is followed by a single-cycle CEnd pulse inside a programmable latency window [MIN_CYC, MAX_CYC].
- Flags violations with a sticky Error, an error code, a saturating error counter, and the last legal measured latency.
- Sits beside handshake-driven datapaths as a protocol watchdog.
- Defaults MIN_CYC = MAX_CYC = 2 give the team's fixed two-cycle check.

Parameters:
- CNT_W, 4: latency counter width. Legal range: 1 <= MIN_CYC <= MAX_CYC <= 2^CNT_W-1.
- MIN_CYC, 2: earliest legal CEnd, in cycles after CStart is sampled.
- MAX_CYC, 2: latest legal CEnd, in cycles after CStart is sampled.
- ERRCNT_W, 8: error counter width.
- RESTART_ON_START, 0:
  - 1: a CStart while COUNT restarts the measurement.
  - 0: a CStart while COUNT is an OVERLAP error.
- STRAY_CHECK, 1: 1 flags a CEnd seen in IDLE.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- CStart  in  1  start event, sampled each edge
- CEnd  in  1  end event, sampled each edge
- ErrorRst  in  1  leaves ERROR, clears Error and ErrCode
- Busy  out  1  high in COUNT or END
- Error  out  1  sticky violation flag
- ErrCode  out  3  code of the first violation: 0 none, 1 EARLY, 2 LATE, 3 WIDTH, 4 OVERLAP, 5 STRAY
- ErrCnt  out  ERRCNT_W  violations since Rst; saturates at all-ones
- LastLat  out  CNT_W  latency d of the last legal transaction

Behaviour:
- All outputs are registered. States: IDLE, COUNT, END, ERROR.
- Rst (priority over everything): state=IDLE, cnt=0, Busy=0, Error=0, ErrCode=0, ErrCnt=0, LastLat=0.
- Entering ERROR on edge E:
  - Error=1 and ErrCode=code are set on edge E itself (zero extra latency).
  - ErrCnt increments on edge E unless saturated.
- IDLE:
  - CStart=1 -> COUNT, cnt<=1. CEnd on the same edge is ignored.
  - Else CEnd=1 and STRAY_CHECK=1 -> ERROR, STRAY.
  - Else stay in IDLE.
- COUNT (cnt = d, cycles since CStart sampled). CEnd is evaluated first:
  - CEnd=1, cnt<MIN_CYC -> ERROR, EARLY.
  - CEnd=1, cnt>=MIN_CYC -> END, LastLat<=cnt. A simultaneous CStart is ignored.
  - CEnd=0, CStart=1, RESTART_ON_START=1 -> cnt<=1, stay in COUNT.
  - CEnd=0, CStart=1, RESTART_ON_START=0 -> ERROR, OVERLAP.
  - CEnd=0, cnt==MAX_CYC -> ERROR, LATE.
  - Otherwise cnt<=cnt+1. The counter never wraps because the MAX_CYC check fires first.
- END (one cycle after a legal CEnd):
  - CEnd=1 -> ERROR, WIDTH. This takes priority over CStart.
  - CEnd=0, CStart=1 -> COUNT, cnt<=1 (back-to-back transactions allowed).
  - Otherwise -> IDLE.
- ERROR:
  - Error stays 1; ErrCode holds the first code; further events are not counted.
  - ErrorRst=1 -> IDLE, Error<=0, ErrCode<=0. CStart on the same edge is ignored.
  - ErrCnt and LastLat are cleared only by Rst.
- Rst asserted mid-transaction aborts it with no error logged.
- Busy <= 1 exactly when next state is COUNT or END.

Test Plan:
- Defaults. CStart at edge 0, CEnd at edge 2 only -> no Error, LastLat=2; Busy high over edges 1-3, low after edge 3.
- Defaults. CStart at edge 0, CEnd at edge 1 -> Error=1, ErrCode=1 at edge 1, ErrCnt=1. ErrorRst at edge 4 -> Error=0, ErrCode=0 at edge 4, ErrCnt stays 1.
- MIN=3, MAX=5.
  - CStart at edge 0, no CEnd -> ErrCode=2 at edge 5.
  - Repeat with CEnd at edge 4 -> LastLat=4, no Error.
- Defaults. CEnd held high at edges 2 and 3 -> ErrCode=3 at edge 3.
- Defaults, back-to-back:
  - CStart at edge 0, CEnd at edge 2, CStart at edge 3, CEnd at edge 5 -> two legal transactions, Error stays 0.
- Overlap, CStart at edges 0 and 1:
  - RESTART_ON_START=0 -> ErrCode=4 at edge 1.
  - RESTART_ON_START=1, CEnd at edge 3 -> LastLat=2.
- ERRCNT_W=2. Five violations, each cleared with ErrorRst -> ErrCnt saturates at 3.
- Rst asserted in COUNT -> IDLE, all outputs 0.
